// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: machine word, control flags and the ROB entry layout.
package rob_pkg;

  localparam int ROB_TAG_MAX_W = 8;

  typedef logic [31:0] MemoryWord;

  typedef struct packed {
    logic flush;
    logic is_branch;
    logic is_jump;
  } rob_ctrl_t;

  // The tag field is sized for the largest supported buffer; smaller buffers zero-extend.
  typedef struct packed {
    MemoryWord                pc;
    logic [ROB_TAG_MAX_W-1:0] tag;
    logic                     ready;
    MemoryWord                value;
    logic [4:0]               dest_reg;
    rob_ctrl_t                ctrl_bits;
  } rob_entry;

endpackage

// File: rtl/rob_queue.sv
// Circular reorder buffer between dispatch and retire: in-order allocate, out-of-order
// writeback, in-order pop of the oldest ready entry, single-cycle flush.
module rob_queue
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  rob_entry         alloc_entry,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_ack,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  MemoryWord        wb_value,
  input  logic             wb_mispredict,
  output rob_entry         rob_head,
  input  logic             rob_decrement,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [TAG_W:0]   count
);

  rob_entry         slots [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count_q;
  logic             pop;
  logic             wb_accept;
  rob_entry         new_entry;

  assign count     = count_q;
  assign full      = (count_q == (TAG_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign alloc_tag = tail;
  assign alloc_ack = alloc_valid && !full && !flush;
  assign rob_head  = empty ? '0 : slots[head];
  assign pop       = rob_decrement && !empty && rob_head.ready;
  assign wb_accept = wb_valid && valid[wb_tag] && !slots[wb_tag].ready && !flush;

  // Dispatch-supplied bookkeeping fields are replaced so a new entry always starts unresolved.
  always_comb begin
    new_entry                 = alloc_entry;
    new_entry.tag             = ROB_TAG_MAX_W'(tail);
    new_entry.ready           = 1'b0;
    new_entry.value           = '0;
    new_entry.ctrl_bits.flush = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      if (alloc_ack) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count_q <= count_q + {{TAG_W{1'b0}}, alloc_ack} - {{TAG_W{1'b0}}, pop};
    end
  end

  // Payload storage needs no reset: the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc_ack) begin
        slots[tail] <= new_entry;
      end
      if (wb_accept) begin
        slots[wb_tag].ready           <= 1'b1;
        slots[wb_tag].value           <= wb_value;
        slots[wb_tag].ctrl_bits.flush <= wb_mispredict;
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed scoreboard bench for rob_queue: stimulus queues expected observations per cycle,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_rob_queue;
  import rob_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_valid;
  rob_entry         alloc_entry;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_ack;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  MemoryWord        wb_value;
  logic             wb_mispredict;
  rob_entry         rob_head;
  logic             rob_decrement;
  logic             flush;
  logic             full;
  logic             empty;
  logic [TAG_W:0]   count;

  rob_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_entry(alloc_entry),
    .alloc_tag(alloc_tag), .alloc_ack(alloc_ack),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_mispredict(wb_mispredict),
    .rob_head(rob_head), .rob_decrement(rob_decrement), .flush(flush),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef enum int {F_COUNT, F_EMPTY, F_FULL, F_ALLOC_TAG, F_ALLOC_ACK, F_HEAD_PC,
                    F_HEAD_READY, F_HEAD_VALUE, F_HEAD_FLUSH, F_HEAD_NONZERO} field_t;

  typedef struct {
    int          cyc;
    string       name;
    field_t      field;
    logic [63:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          cycle = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  exp_t        mon_e;
  logic [63:0] mon_act;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] sample(input field_t f);
    case (f)
      F_COUNT:        return 64'(count);
      F_EMPTY:        return 64'(empty);
      F_FULL:         return 64'(full);
      F_ALLOC_TAG:    return 64'(alloc_tag);
      F_ALLOC_ACK:    return 64'(alloc_ack);
      F_HEAD_PC:      return 64'(rob_head.pc);
      F_HEAD_READY:   return 64'(rob_head.ready);
      F_HEAD_VALUE:   return 64'(rob_head.value);
      F_HEAD_FLUSH:   return 64'(rob_head.ctrl_bits.flush);
      F_HEAD_NONZERO: return 64'(|rob_head);
      default:        return 64'hX;
    endcase
  endfunction

  // Expectations are tagged with the cycle they belong to; anything older was missed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      mon_e   = exp_q.pop_front();
      mon_act = sample(mon_e.field);
      n_compared++;
      if (mon_e.cyc != cycle) begin
        n_mismatched++;
        $display("[TB] FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                 mon_e.name, mon_e.cyc, cycle);
      end else if (mon_act !== mon_e.exp) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                 mon_e.name, mon_act, mon_e.exp, cycle);
      end
    end
  end

  task automatic checkOutput(input string name, input field_t f, input logic [63:0] exp);
    exp_t e;
    e.cyc   = cycle;
    e.name  = name;
    e.field = f;
    e.exp   = exp;
    exp_q.push_back(e);
  endtask

  // Bookkeeping fields are deliberately dirty so the DUT has to overwrite them.
  task automatic applyStimulus(input logic av, input logic [31:0] pc,
                               input logic wv, input logic [TAG_W-1:0] wt,
                               input logic [31:0] wval, input logic wm,
                               input logic dec, input logic fl);
    rob_entry e;
    e                 = '0;
    e.pc              = pc;
    e.tag             = '1;
    e.ready           = 1'b1;
    e.value           = 32'hDEADBEEF;
    e.dest_reg        = 5'd7;
    e.ctrl_bits.flush = 1'b1;
    alloc_valid   = av;
    alloc_entry   = e;
    wb_valid      = wv;
    wb_tag        = wt;
    wb_value      = wval;
    wb_mispredict = wm;
    rob_decrement = dec;
    flush         = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    checkOutput("reset_count", F_COUNT, 0);
    checkOutput("reset_empty", F_EMPTY, 1);
    checkOutput("reset_full", F_FULL, 0);
    checkOutput("reset_alloc_tag", F_ALLOC_TAG, 0);
    checkOutput("reset_alloc_ack", F_ALLOC_ACK, 0);
    checkOutput("reset_head_zero", F_HEAD_NONZERO, 0);
    step();

    // Three allocations, then a pop attempt on an unready head
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("a0_tag", F_ALLOC_TAG, 0);
    checkOutput("a0_ack", F_ALLOC_ACK, 1);
    step();
    applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 0);
    checkOutput("a1_tag", F_ALLOC_TAG, 1);
    checkOutput("a1_count", F_COUNT, 1);
    step();
    applyStimulus(1, 32'h108, 0, 0, 0, 0, 0, 0);
    checkOutput("a2_tag", F_ALLOC_TAG, 2);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("three_count", F_COUNT, 3);
    checkOutput("three_head_pc", F_HEAD_PC, 64'h100);
    checkOutput("three_head_ready", F_HEAD_READY, 0);
    checkOutput("three_head_value", F_HEAD_VALUE, 0);
    checkOutput("three_head_flush", F_HEAD_FLUSH, 0);
    step();
    idle();
    checkOutput("nopop_count", F_COUNT, 3);
    checkOutput("nopop_head_pc", F_HEAD_PC, 64'h100);
    step();

    // Out-of-order writeback, then two pops
    applyStimulus(0, 0, 1, 1, 32'h55, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 0, 32'h11, 0, 0, 0);
    checkOutput("wb_nobypass_ready", F_HEAD_READY, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("wb0_ready", F_HEAD_READY, 1);
    checkOutput("wb0_value", F_HEAD_VALUE, 64'h11);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("pop1_value", F_HEAD_VALUE, 64'h55);
    checkOutput("pop1_pc", F_HEAD_PC, 64'h104);
    checkOutput("pop1_count", F_COUNT, 2);
    step();
    idle();
    checkOutput("pop2_count", F_COUNT, 1);
    checkOutput("pop2_pc", F_HEAD_PC, 64'h108);
    checkOutput("pop2_ready", F_HEAD_READY, 0);
    step();

    // Flush, then fill to DEPTH and exercise the full boundary
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("fill%0d_tag", i), F_ALLOC_TAG, 64'(i));
      checkOutput($sformatf("fill%0d_ack", i), F_ALLOC_ACK, 1);
      if (i == 0) checkOutput("post_flush_empty", F_EMPTY, 1);
      step();
    end
    applyStimulus(0, 0, 1, 0, 32'hA0, 0, 0, 0);
    checkOutput("fill_full", F_FULL, 1);
    checkOutput("fill_count", F_COUNT, 16);
    step();
    applyStimulus(1, 32'h2000, 0, 0, 0, 0, 1, 0);
    checkOutput("full_pop_full", F_FULL, 1);
    checkOutput("full_pop_ack", F_ALLOC_ACK, 0);
    checkOutput("full_pop_value", F_HEAD_VALUE, 64'hA0);
    step();
    applyStimulus(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    checkOutput("after_pop_count", F_COUNT, 15);
    checkOutput("after_pop_full", F_FULL, 0);
    checkOutput("wrap_tag", F_ALLOC_TAG, 0);
    checkOutput("wrap_ack", F_ALLOC_ACK, 1);
    step();
    idle();
    checkOutput("refill_count", F_COUNT, 16);
    checkOutput("refill_head_pc", F_HEAD_PC, 64'h1004);
    step();

    // Mispredict writeback, duplicate writeback, then pop+flush+alloc together
    applyStimulus(0, 0, 1, 1, 32'h200, 1, 0, 0);
    step();
    idle();
    checkOutput("mp_flush", F_HEAD_FLUSH, 1);
    checkOutput("mp_value", F_HEAD_VALUE, 64'h200);
    checkOutput("mp_ready", F_HEAD_READY, 1);
    step();
    applyStimulus(0, 0, 1, 1, 32'h999, 0, 0, 0);
    step();
    idle();
    checkOutput("dup_mp_value", F_HEAD_VALUE, 64'h200);
    checkOutput("dup_mp_flush", F_HEAD_FLUSH, 1);
    step();
    applyStimulus(1, 32'h3000, 0, 0, 0, 0, 1, 1);
    checkOutput("flush_alloc_ack", F_ALLOC_ACK, 0);
    step();
    idle();
    checkOutput("flushed_empty", F_EMPTY, 1);
    checkOutput("flushed_count", F_COUNT, 0);
    checkOutput("flushed_alloc_tag", F_ALLOC_TAG, 0);
    checkOutput("flushed_head_zero", F_HEAD_NONZERO, 0);
    checkOutput("flushed_full", F_FULL, 0);
    step();

    // Stale, duplicate and same-cycle-as-alloc writebacks are all dropped
    applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 32'h4004, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 0, 32'h11, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("s_head_value", F_HEAD_VALUE, 64'h11);
    step();
    applyStimulus(0, 0, 1, 0, 32'hBAD, 0, 0, 0);
    checkOutput("stale_head_pc", F_HEAD_PC, 64'h4004);
    checkOutput("stale_head_flush", F_HEAD_FLUSH, 0);
    step();
    idle();
    checkOutput("stale_count", F_COUNT, 1);
    checkOutput("stale_head_ready", F_HEAD_READY, 0);
    step();
    applyStimulus(0, 0, 1, 1, 32'h22, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 1, 32'h33, 1, 0, 0);
    checkOutput("dup_first_value", F_HEAD_VALUE, 64'h22);
    step();
    idle();
    checkOutput("dup_kept_value", F_HEAD_VALUE, 64'h22);
    checkOutput("dup_kept_flush", F_HEAD_FLUSH, 0);
    step();
    applyStimulus(1, 32'h4008, 1, 2, 32'h66, 0, 0, 0);
    checkOutput("samecyc_tag", F_ALLOC_TAG, 2);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    idle();
    checkOutput("samecyc_head_pc", F_HEAD_PC, 64'h4008);
    checkOutput("samecyc_head_ready", F_HEAD_READY, 0);
    checkOutput("samecyc_count", F_COUNT, 1);
    step();

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h5000 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      step();
    end
    applyStimulus(1, 32'h6000, 1, 2, 32'h1, 0, 0, 0);
    reset = 1'b1;
    checkOutput("pre_reset_count", F_COUNT, 5);
    step();
    reset = 1'b0;
    idle();
    checkOutput("mid_reset_count", F_COUNT, 0);
    checkOutput("mid_reset_empty", F_EMPTY, 1);
    checkOutput("mid_reset_head_zero", F_HEAD_NONZERO, 0);
    checkOutput("mid_reset_alloc_tag", F_ALLOC_TAG, 0);
    step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
